// File: rtl/vrc_pkg.sv
// ---------------------------------------------------------------------------
// vrc_pkg
// Shared definitions for the vector replay checker slice.
//   - default WIDTH / NUM_VECTORS / SETTLE values
//   - width of the settle timer counter
//   - the checker state enum
//   - the expected-vector record type {pattern, expected}
// ---------------------------------------------------------------------------
package vrc_pkg;

    localparam int DEFAULT_WIDTH       = 6;
    localparam int DEFAULT_NUM_VECTORS = 64;
    localparam int DEFAULT_SETTLE      = 1;

    // SETTLE is limited to 0..15, so four bits always hold it
    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        APPLY  = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } vrc_state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] pattern;
        logic                     expected;
    } vrc_record_t;

endpackage

// File: rtl/vrc_if.sv
// ---------------------------------------------------------------------------
// vrc_if
// Expected-vector record stream feeding the replay checker.
//   vec_valid     source has a record
//   vec_ready     checker takes a record this cycle
//   vec_pattern   stimulus pattern of the record
//   vec_expected  golden response for vec_pattern
// master = record source, slave = checker.
// ---------------------------------------------------------------------------
interface vrc_if
    import vrc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] vec_pattern;
    logic             vec_expected;

    modport master (
        output vec_valid,
        output vec_pattern,
        output vec_expected,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_pattern,
        input  vec_expected,
        output vec_ready
    );

endinterface

// File: rtl/vrc_settle_timer.sv
// ---------------------------------------------------------------------------
// vrc_settle_timer
// Loadable down-counter that times the APPLY phase.
//   CK          clock, posedge
//   reset       synchronous active-high reset, clears the count
//   load        load load_value into the counter
//   load_value  number of settle cycles to wait
//   enable      high while the checker sits in APPLY; decrements the count
//   expire      high in the last enabled cycle (count == 1)
// ---------------------------------------------------------------------------
module vrc_settle_timer
    import vrc_pkg::*;
#(
    parameter int CNT_W = SETTLE_W
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // Count register: load wins over decrement, and the count never
    // underflows so a stray enable at zero is harmless.
    always_ff @(posedge CK) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Expiring on count==1 makes APPLY last exactly load_value cycles,
    // since the state leaves APPLY on the edge that ends that cycle.
    assign expire = enable && (count == CNT_W'(1));

endmodule

// File: rtl/vector_replay_checker.sv
// ---------------------------------------------------------------------------
// vector_replay_checker
// Replays a stream of {pattern, expected} records onto a DUT, waits SETTLE
// cycles, samples the DUT response and counts mismatches.
//   CK                  clock, posedge
//   reset               synchronous active-high reset
//   start               one-cycle run request (honoured in IDLE/DONE only)
//   vec                 record stream (vrc_if slave)
//   dut_n               pattern driven to the DUT under check
//   dut_out             DUT response, compared in SAMPLE
//   busy                high in FETCH, APPLY, SAMPLE
//   done                high in DONE until the next accepted start
//   pass                done with zero mismatches
//   mismatch_count      saturating mismatch count for the current run
//   first_fail_valid    a mismatch has been captured this run
//   first_fail_pattern  pattern of the first mismatch
// ---------------------------------------------------------------------------
module vector_replay_checker
    import vrc_pkg::*;
#(
    parameter  int WIDTH       = DEFAULT_WIDTH,
    parameter  int NUM_VECTORS = DEFAULT_NUM_VECTORS,
    parameter  int SETTLE      = DEFAULT_SETTLE,
    localparam int CNT_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    vrc_if.slave             vec,
    output logic [WIDTH-1:0] dut_n,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_pattern
);

    vrc_state_t       state;
    vrc_state_t       next_state;
    logic [CNT_W-1:0] vec_cnt;
    logic             expected_bit;

    logic             start_run;
    logic             accept;
    logic             sample_now;
    logic             timer_load;
    logic             timer_en;
    logic             timer_expire;

    vrc_settle_timer #(
        .CNT_W (SETTLE_W)
    ) u_settle_timer (
        .CK         (CK),
        .reset      (reset),
        .load       (timer_load),
        .load_value (SETTLE_W'(SETTLE)),
        .enable     (timer_en),
        .expire     (timer_expire)
    );

    // State register; reset drops any run in progress back to IDLE.
    always_ff @(posedge CK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes. Start is only looked at in IDLE and
    // DONE, so a start while busy falls through untouched. A FETCH with no
    // valid record just holds, which is the stall behaviour.
    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        accept     = 1'b0;
        sample_now = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_run  = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (vec.vec_valid) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    next_state = (SETTLE == 0) ? SAMPLE : APPLY;
                end
            end
            APPLY: begin
                timer_en = 1'b1;
                if (timer_expire) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_now = 1'b1;
                next_state = (vec_cnt == CNT_W'(NUM_VECTORS - 1)) ? DONE : FETCH;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: the pattern lands on dut_n the cycle after acceptance and
    // stays there through DONE/IDLE. Results are cleared only by an accepted
    // start or by reset. The first mismatch snapshots dut_n, which still
    // carries the pattern being sampled.
    always_ff @(posedge CK) begin
        if (reset) begin
            dut_n              <= '0;
            expected_bit       <= 1'b0;
            vec_cnt            <= '0;
            mismatch_count     <= '0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
        end else begin
            if (start_run) begin
                vec_cnt            <= '0;
                mismatch_count     <= '0;
                first_fail_valid   <= 1'b0;
                first_fail_pattern <= '0;
            end
            if (accept) begin
                dut_n        <= vec.vec_pattern;
                expected_bit <= vec.vec_expected;
            end
            if (sample_now) begin
                vec_cnt <= vec_cnt + 1'b1;
                if (dut_out != expected_bit) begin
                    if (mismatch_count != '1) begin
                        mismatch_count <= mismatch_count + 1'b1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_valid   <= 1'b1;
                        first_fail_pattern <= dut_n;
                    end
                end
            end
        end
    end

    assign vec.vec_ready = (state == FETCH);
    assign busy          = (state == FETCH) || (state == APPLY) || (state == SAMPLE);
    assign done          = (state == DONE);
    assign pass          = done && (mismatch_count == '0);

endmodule
